// File: rtl/stopwatch_display.sv
// Stopwatch reader: samples binary MM:SS on request, converts to BCD by sequential
// double-dabble, and scans the result onto a 4-digit common-anode 7-segment display.
module stopwatch_display #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned PRESC_W  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] minutes,
   input  logic [5:0] seconds,
   input  logic       sample_req,
   output logic       busy,
   output logic       done,
   output logic       min_ovf,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   typedef enum logic {
      S_IDLE,
      S_CONV
   } state_t;

   state_t r_state;
   state_t w_next;

   logic               r_fin;
   logic               r_pend;
   logic               r_busy;
   logic               r_done;
   logic               r_ovf;
   logic [2:0]         r_cnt;
   logic [19:0]        r_sh_m;
   logic [15:0]        r_sh_s;
   logic [3:0]         r_d3;
   logic [3:0]         r_d2;
   logic [3:0]         r_d1;
   logic [3:0]         r_d0;
   logic [PRESC_W-1:0] r_presc;
   logic [1:0]         r_sel;
   logic [3:0]         r_an;
   logic [6:0]         r_seg;
   logic               r_dp;
   logic               w_capture;
   logic [3:0]         w_digit;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // The completion edge (r_fin set) is an IDLE edge that must not capture.
   assign w_capture = (r_state == S_IDLE) && !r_fin && (sample_req || r_pend);

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_capture) w_next = S_CONV;
         S_CONV: if (r_cnt == 3'd7) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Scratch is {BCD, operand} shifted as one word. Minutes hundreds and seconds tens
   // never reach 5 before a shift, so only the nibbles that can are adjusted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fin  <= 1'b0;
         r_pend <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_ovf  <= 1'b0;
         r_cnt  <= '0;
         r_sh_m <= '0;
         r_sh_s <= '0;
         r_d3   <= '0;
         r_d2   <= '0;
         r_d1   <= '0;
         r_d0   <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_busy && sample_req) r_pend <= 1'b1;
         if (w_capture) begin
            r_sh_m <= {12'd0, minutes};
            r_sh_s <= {10'd0, seconds};
            r_cnt  <= '0;
            r_pend <= 1'b0;
            r_busy <= 1'b1;
         end
         if (r_state == S_CONV) begin
            r_sh_m <= {r_sh_m[18:16], add3(r_sh_m[15:12]), add3(r_sh_m[11:8]),
                       r_sh_m[7:0], 1'b0};
            r_sh_s <= {r_sh_s[14:12], add3(r_sh_s[11:8]), r_sh_s[7:0], 1'b0};
            r_cnt  <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) r_fin <= 1'b1;
         end
         if (r_state == S_IDLE && r_fin) begin
            r_fin  <= 1'b0;
            r_d3   <= r_sh_m[15:12];
            r_d2   <= r_sh_m[11:8];
            r_d1   <= r_sh_s[15:12];
            r_d0   <= r_sh_s[11:8];
            r_ovf  <= |r_sh_m[19:16];
            r_done <= 1'b1;
            r_busy <= 1'b0;
         end
      end
   end

   always_comb begin
      w_digit = r_d0;
      case (r_sel)
         2'd0: w_digit = r_d0;
         2'd1: w_digit = r_d1;
         2'd2: w_digit = r_d2;
         2'd3: w_digit = r_d3;
         default: w_digit = r_d0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
         r_sel   <= '0;
         r_an    <= 4'b1110;
         r_seg   <= 7'b1000000;
         r_dp    <= 1'b1;
      end else begin
         if (r_presc == PRESC_W'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            r_sel   <= r_sel + 2'd1;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
         r_an  <= ~(4'b0001 << r_sel);
         r_seg <= seg_decode(w_digit);
         r_dp  <= (r_sel != 2'd2);
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign min_ovf = r_ovf;
   assign an      = r_an;
   assign seg     = r_seg;
   assign dp      = r_dp;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display: conversion latency, request handling,
// reset abort, and scanned digit/segment/colon output at SCAN_DIV=4.
module tb_stopwatch_display;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic       sample_req;
  logic       busy;
  logic       done;
  logic       min_ovf;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (done) n_done++;
  end

  stopwatch_display #(.SCAN_DIV(4), .PRESC_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .minutes    (minutes),
    .seconds    (seconds),
    .sample_req (sample_req),
    .busy       (busy),
    .done       (done),
    .min_ovf    (min_ovf),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  task automatic chk(input string tag, input bit ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s: observed mismatch expected match", tag);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Called just after a posedge with the DUT idle; returns just after the posedge after done.
  task automatic convert(input logic [7:0] m, input logic [5:0] s, input logic ovf_exp,
                         input string tag);
    int   lat;
    logic seen;
    minutes    = m;
    seconds    = s;
    sample_req = 1'b1;
    @(posedge clk);
    #1 sample_req = 1'b0;
    chk($sformatf("%s/busy_start", tag), busy === 1'b1);
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 30 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    chk($sformatf("%s/latency", tag), lat == 9);
    chk($sformatf("%s/busy_end", tag), busy === 1'b0);
    chk($sformatf("%s/min_ovf", tag), min_ovf === ovf_exp);
    @(posedge clk);
    #1;
    chk($sformatf("%s/done_pulse", tag), done === 1'b0);
  endtask

  task automatic scan_chk(input int d3, input int d2, input int d1, input int d0,
                          input int ncyc, input bit need_all, input string tag);
    int dig[4];
    bit seen[4];
    int nseen;
    dig[0] = d0;
    dig[1] = d1;
    dig[2] = d2;
    dig[3] = d3;
    for (int k = 0; k < 4; k++) seen[k] = 1'b0;
    nseen = 0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        if (!seen[k] && an == 4'(~(4'b0001 << k))) begin
          seen[k] = 1'b1;
          nseen++;
          chk($sformatf("%s/seg%0d", tag, k), seg === seg_of(dig[k]));
          chk($sformatf("%s/dp%0d", tag, k), dp === ((k == 2) ? 1'b0 : 1'b1));
        end
      end
    end
    if (need_all) chk($sformatf("%s/all_digits", tag), nseen == 4);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   nd0, c1, c2, last, nd, nlow;
    logic seen;

    reset      = 1'b1;
    sample_req = 1'b0;
    minutes    = '0;
    seconds    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/an", an === 4'b1110);
    chk("rst/seg", seg === 7'b1000000);
    chk("rst/dp", dp === 1'b1);
    chk("rst/busy", busy === 1'b0);
    chk("rst/done", done === 1'b0);
    chk("rst/min_ovf", min_ovf === 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    convert(8'd7, 6'd45, 1'b0, "t07_45");
    scan_chk(0, 7, 4, 5, 40, 1'b1, "t07_45");

    convert(8'd123, 6'd9, 1'b1, "t123_09");
    scan_chk(2, 3, 0, 9, 40, 1'b1, "t123_09");

    convert(8'd255, 6'd63, 1'b1, "t255_63");
    scan_chk(5, 5, 6, 3, 40, 1'b1, "t255_63");

    // request while busy: one pending conversion captured at E10
    minutes    = 8'd12;
    seconds    = 6'd34;
    sample_req = 1'b1;
    @(posedge clk);
    #1 sample_req = 1'b0;
    nd0 = n_done;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1;
      if (e == 2) begin
        minutes = 8'd56;
        seconds = 6'd7;
      end
      if (e == 4) sample_req = 1'b1;
      if (e == 5) sample_req = 1'b0;
    end
    chk("pend/done1", done === 1'b1);
    c1 = cyc;
    scan_chk(1, 2, 3, 4, 7, 1'b0, "pend/first");
    seen = 1'b0;
    c2   = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        c2   = cyc;
      end
    end
    chk("pend/done2_spacing", (c2 - c1) == 10);
    scan_chk(5, 6, 0, 7, 40, 1'b1, "pend/second");
    chk("pend/done_count", (n_done - nd0) == 2);

    // held request: back-to-back every 10 cycles
    minutes    = 8'd42;
    seconds    = 6'd17;
    sample_req = 1'b1;
    last = -1;
    nd   = 0;
    nlow = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        nd++;
        if (last >= 0) chk("held/period", (cyc - last) == 10);
        last = cyc;
      end
      if (!busy) nlow++;
    end
    sample_req = 1'b0;
    chk("held/done_count", nd == 4);
    chk("held/busy_low", nlow == 4);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("held/trailing_done", seen === 1'b1);
    scan_chk(4, 2, 1, 7, 40, 1'b1, "held");

    // reset mid-conversion
    convert(8'd11, 6'd22, 1'b0, "t11_22");
    scan_chk(1, 1, 2, 2, 40, 1'b1, "t11_22");
    minutes    = 8'd33;
    seconds    = 6'd33;
    sample_req = 1'b1;
    @(posedge clk);
    #1 sample_req = 1'b0;
    nd0 = n_done;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort/busy", busy === 1'b0);
    chk("abort/an", an === 4'b1110);
    chk("abort/seg", seg === 7'b1000000);
    chk("abort/dp", dp === 1'b1);
    chk("abort/min_ovf", min_ovf === 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("abort/no_done", (n_done - nd0) == 0);
    scan_chk(0, 0, 0, 0, 40, 1'b1, "abort");
    convert(8'd33, 6'd33, 1'b0, "t33_33");
    scan_chk(3, 3, 3, 3, 40, 1'b1, "t33_33");

    // boundaries
    convert(8'd0, 6'd0, 1'b0, "t00_00");
    scan_chk(0, 0, 0, 0, 40, 1'b1, "t00_00");
    convert(8'd99, 6'd59, 1'b0, "t99_59");
    scan_chk(9, 9, 5, 9, 40, 1'b1, "t99_59");
    convert(8'd100, 6'd60, 1'b1, "t100_60");
    scan_chk(0, 0, 6, 0, 40, 1'b1, "t100_60");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stopwatch_display.md
Name: stopwatch_display

Overview:
- Reader side of the stopwatch time counters.
- On request, samples the binary minutes (0-255) and seconds (0-63) counter values and converts them to BCD with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the result as MM:SS onto a 4-digit common-anode 7-segment display.
- Sits between the minutes/seconds counters and the board display pins.

Parameters:
- SCAN_DIV, 50000, clock cycles each digit is held; legal range 2..65535.
- PRESC_W, 16, prescaler counter width; must hold SCAN_DIV-1.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- minutes  input  8  binary minutes from the minutes counter
- seconds  input  6  binary seconds from the seconds counter
- sample_req  input  1  request a new conversion (level or pulse)
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse: display digit registers just updated
- min_ovf  output  1  last converted minutes value was >= 100
- an  output  4  digit anodes, active-low, one-hot; an[0] = seconds ones
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low; lit only on an[2] (colon)

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - FSM to IDLE; pending flag cleared; digit regs d3..d0 = 0.
  - min_ovf=0, busy=0, done=0, prescaler=0, digit select=0.
  - an=4'b1110, seg=7'b1000000, dp=1.
  - Reset overrides every other input and aborts a conversion mid-flight; no partial result reaches the digit regs.
- FSM states: IDLE, CONV.
  - IDLE: if sample_req or pending at edge E0: capture minutes and {2'b00,seconds} into shift operands, clear BCD scratch and pending, shift count=0, go CONV. busy=1 from after E0.
  - CONV: both 8-bit operands are converted in parallel (12-bit BCD scratch each).
    - Each edge E1..E8: add 3 to every scratch nibble >=5, then shift left one bit, bringing in the operand MSB.
    - At E8 (count=7): go IDLE.
  - At E9 (first IDLE edge after E8), the completion edge:
    - d3,d2 <= minutes tens,ones; d1,d0 <= seconds tens,ones.
    - min_ovf <= (minutes hundreds nibble != 0).
    - done=1 for exactly the cycle after E9; busy=0 after E9.
  - Latency: done is asserted 9 cycles after the capture edge.
- Request and capture rules:
  - Inputs are sampled only at the capture edge, not at request time.
  - sample_req=1 while busy (E0..E9 inclusive) sets pending. Multiple requests collapse into one.
  - A pending request captures at E10 (the first IDLE edge after completion).
  - Continuously held sample_req gives back-to-back conversions every 10 cycles.
- Arithmetic and display values:
  - Minutes >= 100 display as minutes mod 100, with min_ovf=1.
  - Seconds 60..63 display literally (60..63); no clamp.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1, independent of the FSM.
  - On the wrap edge, digit select advances 0→1→2→3→0.
  - an, seg and dp are registered from the current select and digit register, so the outputs change one cycle after the select changes.
  - A digit-register update mid-scan appears at the next output register edge; no blanking.
  - Segment map (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble codes >9 cannot occur; decode them as blank (1111111).
- Minutes tens digit is not blanked when zero.

Test Plan:
- Reset release, SCAN_DIV=4, minutes=7, seconds=45, sample_req pulsed one cycle → busy the next cycle; done pulses 9 cycles after the capture edge; min_ovf=0. The an sequence 1110,1101,1011,0111 shows seg codes for 5,4,7,0; dp=0 only with an=1011.
- minutes=123, seconds=9 → displayed digits 2,3,0,9; min_ovf=1. minutes=255, seconds=63 → 5,5,6,3; min_ovf=1.
- Request during conversion: req at E0 with 12:34, change inputs to 56:07 at E3 and pulse req at E5 → first done shows 12:34. Second capture at E10, done after E19 shows 56:07. Exactly two done pulses.
- sample_req held high for 40 cycles → done pulses every 10 cycles; busy low only one cycle between conversions.
- reset asserted for one cycle at E4 of a 33:33 conversion (prior display 11:22) → digits 0,0,0,0, busy=0, done never pulses. The next request converts correctly.
- Boundary values: 0:00 → digits 0000, min_ovf=0. minutes=99 and minutes=100 → 99 with min_ovf=0, then 00 with min_ovf=1.
